// File: rtl/choose_grid_cursor_if.sv
// Selection handoff channel between the choose screen and the game FSM.
// Latency: pure wiring, no storage.
// Backpressure: producer holds sel_valid/sel_id until the consumer raises sel_ack.
interface choose_grid_cursor_if #(
    parameter int ID_W = 8
) ();
    logic            sel_valid;
    logic [ID_W-1:0] sel_id;
    logic            sel_ack;

    modport master (output sel_valid, output sel_id, input sel_ack);
    modport slave  (input sel_valid, input sel_id, output sel_ack);
endinterface

// File: rtl/choose_grid_cursor.sv
// Selection-screen grid cursor: button moves, lock/commit, id handoff, pixel colour.
// Latency: cursor/state 1 clk after a button pulse; vga_data 1 clk after h_cnt/v_cnt.
// Backpressure: committed id is held on sel_if until sel_ack; buttons ignored meanwhile.
module choose_grid_cursor #(
    parameter int          ROWS    = 2,
    parameter int          COLS    = 4,
    parameter int          ID_W    = 8,
    parameter int          CNT_W   = 10,
    parameter int          X0      = 40,
    parameter int          Y0      = 50,
    parameter int          X_PITCH = 120,
    parameter int          Y_PITCH = 200,
    parameter int          CELL_W  = 40,
    parameter int          CELL_H  = 40,
    parameter int          FRAME_T = 2,
    parameter int          BLINK_W = 24,
    parameter logic [11:0] C_BG    = 12'h878,
    parameter logic [11:0] C_CELL  = 12'h555,
    parameter logic [11:0] C_CUR   = 12'hdd3,
    parameter logic [11:0] C_FRAME = 12'hfff,
    parameter logic [11:0] C_LOCK  = 12'hf40
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_left,
    input  logic              btn_right,
    input  logic              btn_ok,
    input  logic              btn_back,
    input  logic [CNT_W-1:0]  h_cnt,
    input  logic [CNT_W-1:0]  v_cnt,
    output logic [11:0]       vga_data,
    output logic [ID_W-1:0]   cursor_id,
    output logic              locked,
    choose_grid_cursor_if.master sel_if
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    // Two guard bits so cell edges plus frame never wrap.
    localparam int PW = CNT_W + 2;

    typedef enum logic [1:0] {
        BROWSE  = 2'd0,
        LOCKED  = 2'd1,
        HANDOFF = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [RW-1:0]      row_q, row_d;
    logic [CW-1:0]      col_q, col_d;
    logic               sel_valid_q, sel_valid_d;
    logic [ID_W-1:0]    sel_id_q, sel_id_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic [11:0]        vga_q, vga_d;

    logic [PW-1:0]      hx, vy, cx0, cy0;
    logic               in_int, in_box, cur_int, cur_box, any_cell;

    assign cursor_id        = ID_W'(int'(row_q) * COLS + int'(col_q) + 1);
    assign locked           = (state_q == LOCKED);
    assign vga_data         = vga_q;
    assign sel_if.sel_valid = sel_valid_q;
    assign sel_if.sel_id    = sel_id_q;

    // Next-state: selection FSM, cursor moves with fixed button priority, blink counter.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        sel_valid_d = sel_valid_q;
        sel_id_d    = sel_id_q;
        blink_d     = blink_q + BLINK_W'(1);
        case (state_q)
            BROWSE: begin
                if (en) begin
                    if (btn_ok) begin
                        state_d = LOCKED;
                    end else if (!btn_back) begin
                        // back outranks moves, so a back pulse swallows any move in the same clk
                        if (btn_up)
                            row_d = (row_q == '0) ? RW'(ROWS - 1) : row_q - RW'(1);
                        else if (btn_down)
                            row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
                        else if (btn_left)
                            col_d = (col_q == '0) ? CW'(COLS - 1) : col_q - CW'(1);
                        else if (btn_right)
                            col_d = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
                    end
                end
            end
            LOCKED: begin
                if (en) begin
                    if (btn_ok) begin
                        state_d     = HANDOFF;
                        sel_valid_d = 1'b1;
                        sel_id_d    = cursor_id;
                    end else if (btn_back) begin
                        state_d = BROWSE;
                    end
                end
            end
            HANDOFF: begin
                // the handshake completes even with the scene disabled
                if (sel_if.sel_ack) begin
                    state_d     = BROWSE;
                    sel_valid_d = 1'b0;
                end
            end
            default: state_d = BROWSE;
        endcase
        if (state_d == LOCKED && state_q != LOCKED)
            blink_d = '0;
    end

    // Pixel colour: scan every cell for hit tests, then apply the layer priority.
    always_comb begin
        hx       = PW'(h_cnt);
        vy       = PW'(v_cnt);
        cx0      = '0;
        cy0      = '0;
        in_int   = 1'b0;
        in_box   = 1'b0;
        cur_int  = 1'b0;
        cur_box  = 1'b0;
        any_cell = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                cx0    = PW'(X0 + c * X_PITCH);
                cy0    = PW'(Y0 + r * Y_PITCH);
                in_int = (hx > cx0) && (hx < cx0 + PW'(CELL_W)) &&
                         (vy > cy0) && (vy < cy0 + PW'(CELL_H));
                // frame box grown by FRAME_T on each side; add on the left to avoid underflow
                in_box = (hx + PW'(FRAME_T) > cx0) && (hx < cx0 + PW'(CELL_W + FRAME_T)) &&
                         (vy + PW'(FRAME_T) > cy0) && (vy < cy0 + PW'(CELL_H + FRAME_T));
                if (RW'(r) == row_q && CW'(c) == col_q) begin
                    cur_int = in_int;
                    cur_box = in_box;
                end else if (in_int) begin
                    any_cell = 1'b1;
                end
            end
        end
        if (cur_int)
            vga_d = (locked && blink_q[BLINK_W-1]) ? C_LOCK : C_CUR;
        else if (cur_box)
            vga_d = C_FRAME;
        else if (any_cell)
            vga_d = C_CELL;
        else
            vga_d = C_BG;
    end

    // State register; reset drops sel_valid immediately, mid-handshake included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BROWSE;
            row_q       <= '0;
            col_q       <= '0;
            sel_valid_q <= 1'b0;
            sel_id_q    <= '0;
            blink_q     <= '0;
            vga_q       <= C_BG;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            sel_valid_q <= sel_valid_d;
            sel_id_q    <= sel_id_d;
            blink_q     <= blink_d;
            vga_q       <= vga_d;
        end
    end
endmodule
